// File: rtl/branch_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] IF_pc;
  logic [31:0] pc_BTB;
  logic        pred_taken;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_is_cond;
  logic        update_taken;
  logic [31:0] update_target;

  // Prediction is combinational from IF_pc. update_en is a single-cycle strobe:
  // there is no ready, so every cycle with update_en=1 is one resolved control op.
  modport master (
    output IF_pc, update_en, update_pc, update_is_cond, update_taken, update_target,
    input  pc_BTB, pred_taken
  );

  modport slave (
    input  IF_pc, update_en, update_pc, update_is_cond, update_taken, update_target,
    output pc_BTB, pred_taken
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus gshare PHT of 2-bit counters; zero-latency prediction,
// single-cycle training from EX.
module branch_predictor #(
  parameter int ENTRIES = 32,
  parameter int HIST_W  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_if.slave    bp,
  output logic [HIST_W-1:0]    bhr_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - 2 - IDX_W;

  logic              valid_q  [ENTRIES];
  logic              uncond_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        pht_q    [ENTRIES];
  logic [HIST_W-1:0] bhr_q;

  logic [IDX_W-1:0]  if_idx, if_pht_idx, upd_idx, upd_pht_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  logic              hit;
  logic [1:0]        pht_cur, pht_d;
  logic [HIST_W-1:0] bhr_d;
  logic              unused_pc_bits;

  assign if_idx      = bp.IF_pc[IDX_W+1:2];
  assign if_tag      = bp.IF_pc[31:IDX_W+2];
  assign if_pht_idx  = if_idx ^ bhr_q;
  assign upd_idx     = bp.update_pc[IDX_W+1:2];
  assign upd_tag     = bp.update_pc[31:IDX_W+2];
  assign upd_pht_idx = upd_idx ^ bhr_q;

  assign unused_pc_bits = &{1'b0, bp.IF_pc[1:0], bp.update_pc[1:0]};

  // Reset clears valid asynchronously, so a miss (pc+4) is forced during reset.
  assign hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp.pred_taken = hit && (uncond_q[if_idx] || pht_q[if_pht_idx][1]);
  assign bp.pc_BTB     = bp.pred_taken ? target_q[if_idx] : (bp.IF_pc + 32'd4);
  assign bhr_o         = bhr_q;

  always_comb begin
    pht_cur = pht_q[upd_pht_idx];
    pht_d   = pht_cur;
    if (bp.update_taken) begin
      if (pht_cur != 2'b11) pht_d = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_d = pht_cur - 2'b01;
    end
    bhr_d = {bhr_q[HIST_W-2:0], bp.update_taken};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        uncond_q[i] <= 1'b0;
        pht_q[i]    <= 2'b01;
      end
      bhr_q <= '0;
    end else if (bp.update_en) begin
      if (bp.update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        uncond_q[upd_idx] <= !bp.update_is_cond;
      end
      if (bp.update_is_cond) begin
        pht_q[upd_pht_idx] <= pht_d;
        bhr_q              <= bhr_d;
      end
    end
  end

  // Tag and target carry no reset; they only matter once valid is set.
  always_ff @(posedge clk) begin
    if (reset && bp.update_en && bp.update_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= bp.update_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: probes push expected {bhr, taken, pc_BTB};
// a negedge monitor pops and compares.
module tb_branch_predictor;
  localparam int W = 38;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] dbg_bhr;
  logic       probe_v = 1'b0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(32), .HIST_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp),
    .bhr_o (dbg_bhr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic probe(input string name, input logic [31:0] pc,
                       input logic [31:0] exp_pc, input logic exp_tk, input logic [4:0] exp_bhr);
    bp.IF_pc = pc;
    exp_q.push_back({exp_bhr, exp_tk, exp_pc});
    name_q.push_back(name);
    probe_v = 1'b1;
    @(negedge clk);
    #1 probe_v = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic is_cond,
                        input logic taken, input logic [31:0] target);
    @(posedge clk);
    #1;
    bp.update_pc      = pc;
    bp.update_is_cond = is_cond;
    bp.update_taken   = taken;
    bp.update_target  = target;
    bp.update_en      = 1'b1;
    @(posedge clk);
    #1 bp.update_en = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (probe_v) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      string        nm;
      act = {dbg_bhr, bp.pred_taken, bp.pc_BTB};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: got output with no expected entry, expected a queued entry");
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got pc_BTB=%h taken=%0b bhr=%0d, expected pc_BTB=%h taken=%0b bhr=%0d",
                   nm, act[31:0], act[32], act[37:33], exp[31:0], exp[32], exp[37:33]);
        end
      end
    end
  end

  initial begin
    reset             = 1'b0;
    bp.IF_pc          = '0;
    bp.update_en      = 1'b0;
    bp.update_pc      = '0;
    bp.update_is_cond = 1'b0;
    bp.update_taken   = 1'b0;
    bp.update_target  = '0;

    probe("reset_hold", 32'h100, 32'h104, 1'b0, 5'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    probe("after_reset", 32'h100, 32'h104, 1'b0, 5'd0);

    update(32'h40, 1'b0, 1'b1, 32'h80);
    probe("jal_hit", 32'h40, 32'h80, 1'b1, 5'd0);

    // gshare training of the branch at 0x20: indices 8, 9, 11 go to 10
    update(32'h20, 1'b1, 1'b1, 32'h10);
    probe("br_taken1", 32'h20, 32'h24, 1'b0, 5'd1);
    update(32'h20, 1'b1, 1'b1, 32'h10);
    probe("br_taken2", 32'h20, 32'h24, 1'b0, 5'd3);
    update(32'h20, 1'b1, 1'b1, 32'h10);
    probe("br_taken3", 32'h20, 32'h24, 1'b0, 5'd7);

    update(32'h50, 1'b1, 1'b1, 32'h300);
    probe("cond_entry_50", 32'h50, 32'h54, 1'b0, 5'd15);

    // not-taken history flush back to bhr=0 via pc 0x200
    for (int i = 0; i < 5; i++) update(32'h200, 1'b1, 1'b0, 32'h999);
    probe("gshare_hit", 32'h20, 32'h10, 1'b1, 5'd0);
    probe("nt_btb_untouched", 32'h200, 32'h204, 1'b0, 5'd0);
    probe("pht20_weak_nt", 32'h50, 32'h54, 1'b0, 5'd0);

    // PHT[20] floor: bhr stays 0 under not-taken updates at 0x50
    for (int i = 0; i < 5; i++) begin
      update(32'h50, 1'b1, 1'b0, 32'h300);
      probe("sat_lo", 32'h50, 32'h54, 1'b0, 5'd0);
    end

    // PHT[20] ceiling: each pc chosen so pc[6:2]^bhr == 20
    update(32'h50, 1'b1, 1'b1, 32'h500);
    update(32'h54, 1'b1, 1'b1, 32'h510);
    update(32'h5C, 1'b1, 1'b1, 32'h520);
    update(32'h4C, 1'b1, 1'b1, 32'h530);
    update(32'h6C, 1'b1, 1'b1, 32'h540);
    for (int i = 0; i < 5; i++) update(32'h200, 1'b1, 1'b0, 32'h0);
    probe("sat_hi", 32'h50, 32'h500, 1'b1, 5'd0);
    update(32'h50, 1'b1, 1'b0, 32'h0);
    probe("sat_hi_dec", 32'h50, 32'h500, 1'b1, 5'd0);

    probe("tag_mismatch", 32'h1040, 32'h1044, 1'b0, 5'd0);
    probe("tag_match", 32'h40, 32'h80, 1'b1, 5'd0);
    update(32'h1040, 1'b0, 1'b1, 32'h2000);
    probe("replace_new", 32'h1040, 32'h2000, 1'b1, 5'd0);
    probe("replace_old", 32'h40, 32'h44, 1'b0, 5'd0);

    update(32'h200, 1'b1, 1'b1, 32'h700);
    probe("pre_reset_bhr", 32'h200, 32'h204, 1'b0, 5'd1);

    // reset lands while an update strobe is pending
    @(posedge clk);
    #1;
    bp.update_pc      = 32'h60;
    bp.update_is_cond = 1'b0;
    bp.update_taken   = 1'b1;
    bp.update_target  = 32'h600;
    bp.update_en      = 1'b1;
    reset             = 1'b0;
    probe("reset_async", 32'h1040, 32'h1044, 1'b0, 5'd0);
    @(posedge clk);
    #1 bp.update_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    probe("reset_discard", 32'h60, 32'h64, 1'b0, 5'd0);
    probe("reset_clr_200", 32'h200, 32'h204, 1'b0, 5'd0);
    probe("reset_clr_50", 32'h50, 32'h54, 1'b0, 5'd0);
    update(32'h20, 1'b1, 1'b1, 32'h10);
    probe("reset_pht", 32'h20, 32'h24, 1'b0, 5'd1);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 32, giving the BTB/PHT depth (power of two).
REQ-002 The block SHALL have parameter HIST_W, default 5, giving the global history width; HIST_W SHALL equal log2(ENTRIES).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port IF_pc, input, 32, the fetch-stage pc to predict.
REQ-006 The block SHALL have port pc_BTB, output, 32, the predicted next fetch pc.
REQ-007 The block SHALL have port pred_taken, output, 1, high when pc_BTB is a BTB target rather than IF_pc+4.
REQ-008 The block SHALL have port update_en, input, 1, a one-cycle EX-stage resolution strobe for a control instruction.
REQ-009 The block SHALL have port update_pc, input, 32, the pc of the resolved instruction (ID_EX_pc).
REQ-010 The block SHALL have port update_is_cond, input, 1, high for BRANCH and low for JAL/JALR.
REQ-011 The block SHALL have port update_taken, input, 1, the resolved direction; callers drive 1 for JAL/JALR.
REQ-012 The block SHALL have port update_target, input, 32, the resolved target (pc+imm or ALU result).

Function
REQ-013 Storage SHALL comprise, per entry: a valid bit, tag = pc[31:7] for the default parameters, a 32-bit target, and a 2-bit saturating counter in a separate PHT.
REQ-014 BTB index SHALL be pc[6:2]; PHT index SHALL be pc[6:2] XOR bhr (gshare).
REQ-015 Hit SHALL be valid[IF_pc[6:2]] && tag matches IF_pc[31:7].
REQ-016 pred_taken SHALL be hit && (entry is unconditional || PHT counter >= 2); the unconditional flag is stored per entry.
REQ-017 pc_BTB SHALL be the stored target when pred_taken is high, else IF_pc+4 (mod 2^32); the prediction is combinational, with zero-cycle latency.
REQ-018 Tables and BHR SHALL be written only at a rising clk edge when update_en=1; reads in the same cycle return pre-write contents (no bypass).
REQ-019 On update with update_taken=1, the BTB entry at update_pc[6:2] SHALL be written with valid=1, the tag, update_target, and unconditional = !update_is_cond, replacing any prior occupant.
REQ-020 On update with update_taken=0, the BTB entry SHALL be left unchanged.
REQ-021 On a conditional update, the PHT entry at update_pc[6:2] XOR bhr (pre-update bhr) SHALL increment when taken, saturating at 3, and decrement when not taken, saturating at 0.
REQ-022 On a conditional update, bhr SHALL shift left by one, inserting update_taken at bit 0 and discarding the MSB.
REQ-023 Unconditional updates SHALL modify neither the PHT nor bhr.
REQ-024 When update_en=0, no state SHALL change; stalls are the caller's responsibility.
REQ-025 Aliasing within the tag scheme is permitted; tag mismatch SHALL always yield pc_BTB = IF_pc+4.

Reset
REQ-026 While reset=0, asynchronously: all valid bits SHALL be 0, all PHT counters SHALL be 2'b01 (weakly not-taken), and bhr SHALL be 0.
REQ-027 During and after reset, pred_taken SHALL be 0 and pc_BTB SHALL equal IF_pc+4.
REQ-028 Reset asserted in the same cycle as update_en SHALL discard the update.
REQ-029 BTB target/tag contents need not be cleared by reset.

Verification
REQ-030 Bench: after reset, IF_pc=0x0000_0100 -> pc_BTB=0x0000_0104, pred_taken=0.
REQ-031 Bench: JAL update (pc=0x40, target=0x80, is_cond=0) -> next cycle IF_pc=0x40 gives pc_BTB=0x80, pred_taken=1, and bhr remains 0.
REQ-032 Bench: branch pc=0x20, target=0x10, taken twice -> 1st update sets PHT[8^0] 01->10 and bhr=1; 2nd sets PHT[8^1] 01->10 and bhr=3; with IF_pc=0x20 and bhr=3, index 11 holds 01 -> pred_taken=0, then after a third taken update PHT[11]=10 (bhr=7), so index 15 holds 01 -> pred_taken=0; with bhr forced equal to a trained index, pred_taken=1.
REQ-033 Bench: saturation -> 5 not-taken conditional updates leave the counter at 00, and 5 taken updates leave it at 11.
REQ-034 Bench: IF_pc=0x1040 vs an entry trained at 0x0040 -> tag mismatch, pc_BTB=0x1044.
REQ-035 Bench: reset pulsed low mid-update with entries valid -> all predictions revert to pc+4 immediately, without waiting for a clock edge.
